// File: rtl/fifo_pkg.sv
// Shared types and helpers for the counted FIFO.
//   fifo_mode_t : read-side behaviour (registered one-cycle read, or first-word-fall-through)
//   fifo_depth  : number of entries addressed by a pointer of the given width
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_MODE_STANDARD,
    FIFO_MODE_FWFT
  } fifo_mode_t;

  function automatic int unsigned fifo_depth(int unsigned address_bits);
    return 32'd1 << address_bits;
  endfunction

endpackage

// File: rtl/fifo_counted_if.sv
// Producer/consumer side bundle of the counted FIFO.
//   master : the pipeline stages driving writes/reads and watching status
//   slave  : the FIFO itself
// Inputs : in_flush, in_write, in_data, in_read
// Outputs: out_data, out_valid, out_full, out_empty, out_almost_full, out_almost_empty,
//          out_count, out_overflow, out_underflow
interface fifo_counted_if #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned ADDRESS_BITS = 4
);

  logic                    in_flush;
  logic                    in_write;
  logic [DATA_BITS-1:0]    in_data;
  logic                    in_read;
  logic [DATA_BITS-1:0]    out_data;
  logic                    out_valid;
  logic                    out_full;
  logic                    out_empty;
  logic                    out_almost_full;
  logic                    out_almost_empty;
  logic [ADDRESS_BITS:0]   out_count;
  logic                    out_overflow;
  logic                    out_underflow;

  modport master (
    output in_flush, in_write, in_data, in_read,
    input  out_data, out_valid, out_full, out_empty, out_almost_full, out_almost_empty,
           out_count, out_overflow, out_underflow
  );

  modport slave (
    input  in_flush, in_write, in_data, in_read,
    output out_data, out_valid, out_full, out_empty, out_almost_full, out_almost_empty,
           out_count, out_overflow, out_underflow
  );

endinterface

// File: rtl/fifo_storage.sv
// Register-array storage for the counted FIFO: one synchronous write port, one
// asynchronous read port, no reset on the array.
//   clk             : write clock
//   wr_en/addr/data : write port
//   rd_addr/rd_data : combinational read port
module fifo_storage import fifo_pkg::*; #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned ADDRESS_BITS = 4
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDRESS_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]    wr_data,
  input  logic [ADDRESS_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0]    rd_data
);

  localparam int unsigned Depth = fifo_depth(ADDRESS_BITS);

  logic [DATA_BITS-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_counted.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a selectable read mode.
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fifo_counted_if.slave (write/read requests in, data and status out)
module fifo_counted import fifo_pkg::*; #(
  parameter int unsigned DATA_BITS           = 8,
  parameter int unsigned ADDRESS_BITS        = 4,
  parameter int unsigned ALMOST_FULL_MARGIN  = 2,
  parameter int unsigned ALMOST_EMPTY_MARGIN = 2,
  parameter fifo_mode_t  MODE                = FIFO_MODE_STANDARD
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_counted_if.slave bus
);

  localparam int unsigned Depth = fifo_depth(ADDRESS_BITS);

  typedef logic [ADDRESS_BITS:0]   count_t;
  typedef logic [ADDRESS_BITS-1:0] ptr_t;

  localparam count_t CountFull = count_t'(Depth);
  localparam count_t AfLevel   = count_t'(Depth - ALMOST_FULL_MARGIN);
  localparam count_t AeLevel   = count_t'(ALMOST_EMPTY_MARGIN);

  if (DATA_BITS < 1) begin : gen_bad_data_bits
    $error("fifo_counted: DATA_BITS must be >= 1");
  end
  if (ADDRESS_BITS < 1) begin : gen_bad_address_bits
    $error("fifo_counted: ADDRESS_BITS must be >= 1");
  end
  if (ALMOST_FULL_MARGIN >= Depth) begin : gen_bad_af_margin
    $error("fifo_counted: ALMOST_FULL_MARGIN must be < DEPTH");
  end
  if (ALMOST_EMPTY_MARGIN >= Depth) begin : gen_bad_ae_margin
    $error("fifo_counted: ALMOST_EMPTY_MARGIN must be < DEPTH");
  end

  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  count_t               count_q, count_d;
  logic                 full_q, empty_q, almost_full_q, almost_empty_q;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_acc, wr_acc, wr_en;

  always_comb begin
    rd_acc = bus.in_read && (count_q != '0);
    // A full FIFO still takes a write when the head leaves on the same edge.
    wr_acc = bus.in_write && ((count_q != CountFull) || rd_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    data_d      = data_q;
    valid_d     = 1'b0;

    if (bus.in_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      data_d      = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
        data_d   = rd_data;
        valid_d  = 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + count_t'(1);
        2'b01:   count_d = count_q - count_t'(1);
        default: count_d = count_q;
      endcase
      if (bus.in_write && !wr_acc) overflow_d  = 1'b1;
      if (bus.in_read  && !rd_acc) underflow_d = 1'b1;
    end
  end

  assign wr_en = wr_acc && !bus.in_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      data_q         <= '0;
      valid_q        <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      // Status tracks the next count so it moves on the same edge as out_count.
      full_q         <= (count_d == CountFull);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AfLevel);
      almost_empty_q <= (count_d <= AeLevel);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
    end
  end

  fifo_storage #(
    .DATA_BITS    (DATA_BITS),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // FWFT shows the head word directly; it is masked while empty so the
  // don't-care array contents never reach the bus (and reset reads as 0).
  assign bus.out_data  = (MODE == FIFO_MODE_FWFT) ? (empty_q ? '0 : rd_data) : data_q;
  assign bus.out_valid = (MODE == FIFO_MODE_FWFT) ? !empty_q : valid_q;

  assign bus.out_count        = count_q;
  assign bus.out_full         = full_q;
  assign bus.out_empty        = empty_q;
  assign bus.out_almost_full  = almost_full_q;
  assign bus.out_almost_empty = almost_empty_q;
  assign bus.out_overflow     = overflow_q;
  assign bus.out_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_counted.sv
// Drives a STANDARD and a FWFT instance with identical stimulus and checks both
// against a queue-based model of the FIFO rules.
module tb_fifo_counted;
  import fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_counted_if #(.DATA_BITS(5), .ADDRESS_BITS(4)) s_if ();
  fifo_counted_if #(.DATA_BITS(5), .ADDRESS_BITS(4)) f_if ();

  fifo_counted #(
    .DATA_BITS(5), .ADDRESS_BITS(4), .ALMOST_FULL_MARGIN(2), .ALMOST_EMPTY_MARGIN(2),
    .MODE(FIFO_MODE_STANDARD)
  ) u_std (.clk(clk), .reset_n(reset_n), .bus(s_if));

  fifo_counted #(
    .DATA_BITS(5), .ADDRESS_BITS(4), .ALMOST_FULL_MARGIN(2), .ALMOST_EMPTY_MARGIN(2),
    .MODE(FIFO_MODE_FWFT)
  ) u_fwft (.clk(clk), .reset_n(reset_n), .bus(f_if));

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [4:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [4:0] m_std_data = '0;
  logic       m_std_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    m_std_data  = '0;
    m_std_valid = 1'b0;
  endtask

  task automatic model_edge(input logic fl, input logic wr, input logic [4:0] d, input logic rd);
    bit ra, wa;
    if (fl) begin
      model_clear();
      return;
    end
    ra = rd && (q.size() != 0);
    wa = wr && ((q.size() != DEPTH) || ra);
    if (ra) begin
      m_std_data  = q.pop_front();
      m_std_valid = 1'b1;
    end else begin
      m_std_valid = 1'b0;
    end
    if (wa) q.push_back(d);
    if (wr && !wa) m_ovf = 1'b1;
    if (rd && !ra) m_unf = 1'b1;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    check({ph, " std_count"},   32'(s_if.out_count), 32'(n));
    check({ph, " fwft_count"},  32'(f_if.out_count), 32'(n));
    check({ph, " std_full"},    32'(s_if.out_full), 32'(n == DEPTH));
    check({ph, " fwft_full"},   32'(f_if.out_full), 32'(n == DEPTH));
    check({ph, " std_empty"},   32'(s_if.out_empty), 32'(n == 0));
    check({ph, " fwft_empty"},  32'(f_if.out_empty), 32'(n == 0));
    check({ph, " std_afull"},   32'(s_if.out_almost_full), 32'(n >= AF));
    check({ph, " fwft_afull"},  32'(f_if.out_almost_full), 32'(n >= AF));
    check({ph, " std_aempty"},  32'(s_if.out_almost_empty), 32'(n <= AE));
    check({ph, " fwft_aempty"}, 32'(f_if.out_almost_empty), 32'(n <= AE));
    check({ph, " std_ovf"},     32'(s_if.out_overflow), 32'(m_ovf));
    check({ph, " fwft_ovf"},    32'(f_if.out_overflow), 32'(m_ovf));
    check({ph, " std_unf"},     32'(s_if.out_underflow), 32'(m_unf));
    check({ph, " fwft_unf"},    32'(f_if.out_underflow), 32'(m_unf));
    check({ph, " std_valid"},   32'(s_if.out_valid), 32'(m_std_valid));
    check({ph, " std_data"},    32'(s_if.out_data), 32'(m_std_data));
    check({ph, " fwft_valid"},  32'(f_if.out_valid), 32'(n != 0));
    if (n != 0) check({ph, " fwft_data"}, 32'(f_if.out_data), 32'(q[0]));
  endtask

  task automatic drive(input logic fl, input logic wr, input logic [4:0] d, input logic rd);
    s_if.in_flush = fl; s_if.in_write = wr; s_if.in_data = d; s_if.in_read = rd;
    f_if.in_flush = fl; f_if.in_write = wr; f_if.in_data = d; f_if.in_read = rd;
  endtask

  // One clock: inputs applied now, edge, model update, sample 1 time unit later.
  task automatic step(input string ph, input logic fl, input logic wr, input logic [4:0] d,
                      input logic rd);
    drive(fl, wr, d, rd);
    @(posedge clk);
    model_edge(fl, wr, d, rd);
    #1;
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    check_all(ph);
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 1'b0);
    model_clear();

    // 1. Reset and idle
    #12;
    check_all("reset");
    check("reset fwft_data", 32'(f_if.out_data), 32'd0);
    reset_n = 1'b1;
    step("idle", 1'b0, 1'b0, 5'd0, 1'b0);
    step("idle", 1'b0, 1'b0, 5'd0, 1'b0);

    // 2. Fill with 0,3,6,... then drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 5'((i * 3) % 32), 1'b0);
    check("fill std_full", 32'(s_if.out_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b0, 5'd0, 1'b1);
      check("drain seq", 32'(s_if.out_data), 32'((i * 3) % 32));
    end
    check("drain std_empty", 32'(s_if.out_empty), 32'd1);

    // 3. Overflow on full, then write+read on full
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b0, 1'b1, 5'(i + 10), 1'b0);
    step("ovf", 1'b0, 1'b1, 5'd31, 1'b0);
    check("ovf flag", 32'(s_if.out_overflow), 32'd1);
    step("full_rw", 1'b0, 1'b1, 5'd30, 1'b1);
    check("full_rw count", 32'(s_if.out_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b0, 5'd0, 1'b1);

    // 4. Underflow on empty, then write+read on empty
    step("flush", 1'b1, 1'b0, 5'd0, 1'b0);
    step("unf", 1'b0, 1'b0, 5'd0, 1'b1);
    check("unf flag", 32'(s_if.out_underflow), 32'd1);
    step("flush", 1'b1, 1'b0, 5'd0, 1'b0);
    step("empty_rw", 1'b0, 1'b1, 5'd7, 1'b1);
    step("read7", 1'b0, 1'b0, 5'd0, 1'b1);
    check("read7 data", 32'(s_if.out_data), 32'd7);

    // 5. FWFT visibility and ordering
    step("fwft w9", 1'b0, 1'b1, 5'd9, 1'b0);
    check("fwft w9 data", 32'(f_if.out_data), 32'd9);
    step("fwft w4", 1'b0, 1'b1, 5'd4, 1'b0);
    step("fwft w17", 1'b0, 1'b1, 5'd17, 1'b0);
    for (int i = 0; i < 3; i++) step("fwft pop", 1'b0, 1'b0, 5'd0, 1'b1);
    check("fwft drained", 32'(f_if.out_valid), 32'd0);

    // 6. Wrap-around, then flush with a concurrent write
    step("flush", 1'b1, 1'b0, 5'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 12; i++) step("wrap w", 1'b0, 1'b1, 5'(i + r * 12), 1'b0);
      for (int i = 0; i < 12; i++) step("wrap r", 1'b0, 1'b0, 5'd0, 1'b1);
    end
    for (int i = 0; i < 5; i++) step("pre_flush", 1'b0, 1'b1, 5'(i), 1'b0);
    step("ovf_pre", 1'b0, 1'b0, 5'd0, 1'b0);
    step("flush_wr", 1'b1, 1'b1, 5'd21, 1'b0);
    check("flush_wr count", 32'(s_if.out_count), 32'd0);

    // 7. Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i % 200 < 100) ? 70 : 30;
      step("rand", ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < wp), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 99) < (100 - wp)));
      if (i == 300) begin
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        check_all("async_reset");
        #1 reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_counted.md
Name: fifo_counted

Overview:
- Parametrised successor to the existing FIFO: synchronous single-clock FIFO with generic width and depth, and an occupancy count.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a selectable read mode (standard or first-word-fall-through).
- Sits between producer/consumer pipeline stages wherever the existing FIFO is used today.

Parameters:
- DATA_BITS, 8, width of each data word.
- ADDRESS_BITS, 4, pointer width; DEPTH = 2**ADDRESS_BITS entries, all usable.
- ALMOST_FULL_MARGIN, 2, out_almost_full asserts when count >= DEPTH - ALMOST_FULL_MARGIN.
- ALMOST_EMPTY_MARGIN, 2, out_almost_empty asserts when count <= ALMOST_EMPTY_MARGIN.
- MODE, FIFO_MODE_STANDARD, fifo_mode_t read mode (FIFO_MODE_STANDARD or FIFO_MODE_FWFT).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_flush  input  1  synchronous clear of contents and sticky flags.
- in_write  input  1  write request.
- in_data  input  DATA_BITS  write data.
- in_read  input  1  read request (STANDARD) or pop acknowledge (FWFT).
- out_data  output  DATA_BITS  read data.
- out_valid  output  1  out_data is valid.
- out_full  output  1  count == DEPTH.
- out_empty  output  1  count == 0.
- out_almost_full  output  1  threshold flag.
- out_almost_empty  output  1  threshold flag.
- out_count  output  ADDRESS_BITS+1  occupancy, 0..DEPTH.
- out_overflow  output  1  sticky: a write was dropped.
- out_underflow  output  1  sticky: a read was dropped.

Behaviour:
- Reset (reset_n low, asynchronous): pointers, count, out_data, out_valid, out_full, out_almost_full, out_overflow and out_underflow clear to 0. out_empty and out_almost_empty go to 1. Storage contents are don't-care.
- Flush has the highest priority. When in_flush=1, the next edge applies the reset state, and any write or read in that cycle is ignored and not flagged.
- Read accepted (rd_acc) = in_read && count != 0.
- Write accepted (wr_acc) = in_write && (count != DEPTH || rd_acc). A write into a full FIFO succeeds only if a read is accepted in the same cycle.
- A write on empty with a simultaneous read: the write is accepted. The read is dropped and sets underflow.
- Dropped write: in_write && !wr_acc, sets out_overflow. Dropped read: in_read && !rd_acc, sets out_underflow. Both flags stay set until reset or flush.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Pointers are ADDRESS_BITS wide and wrap modulo DEPTH naturally.
- Status flags (full, empty, almost_full, almost_empty, out_count) are registered and computed from the next count, so they change on the same edge as the count.
- STANDARD mode:
  - rd_acc at edge N gives out_data = head word and out_valid=1 for the cycle after edge N.
  - out_valid is a one-cycle pulse per accepted read; out_data holds its last value otherwise.
  - Read latency is 1 cycle.
- FWFT mode:
  - out_valid = !out_empty.
  - out_data = storage[rd_ptr] (combinational from registered pointer and storage).
  - in_read acknowledges and pops the head word at the next edge.
  - A word written at edge N appears on out_data after edge N, i.e. 1-cycle write-to-visible latency.
- Data ordering is strictly first-in first-out. No word is duplicated or lost except dropped writes.
- Elaboration checks:
  - ALMOST_FULL_MARGIN and ALMOST_EMPTY_MARGIN must each be < DEPTH.
  - DATA_BITS >= 1 and ADDRESS_BITS >= 1.
  - Violations are reported with $error.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum fifo_mode_t {FIFO_MODE_STANDARD, FIFO_MODE_FWFT};
  - a constant function fifo_depth(address_bits) returning 2**address_bits.
- Sub-module fifo_storage holds the storage:
  - parameters DATA_BITS and ADDRESS_BITS;
  - register array with one synchronous write port (wr_en, wr_addr, wr_data);
  - one asynchronous read port (rd_addr, rd_data);
  - no reset on the array.
- Control, count, flags and mode logic live in fifo_counted.

Test Plan:
All scenarios use DATA_BITS=5, ADDRESS_BITS=4 (DEPTH 16) and margins of 2.
1. Reset then idle -> out_count=0, out_empty=1, out_almost_empty=1, out_valid=0, all other flags 0. Assert reset_n mid-burst -> same state immediately, without waiting for a clock edge.
2. STANDARD mode: write 0,3,6,...,45 mod 32 (16 words) -> out_full=1 after the 16th edge, out_almost_full=1 once count=14. Then read 16 times -> out_data sequence 0,3,6,... with out_valid pulsing 1 cycle after each read, out_empty=1 at the end.
3. Full FIFO, in_write=1 with in_read=0 -> out_overflow=1, count stays 16. Same with in_read=1 -> write accepted, count stays 16, no new overflow, order preserved.
4. Empty FIFO, in_read=1 -> out_underflow=1, count 0. Empty FIFO with write 7 and read in the same cycle -> count=1, underflow set, next read returns 7.
5. FWFT mode: write 9 at edge N -> out_valid=1 and out_data=9 after edge N. Write 4 and 17, then pop 3 times with in_read -> 9, 4, 17 are seen in order, then out_valid=0.
6. Wrap-around and flush:
   - write 12 / read 12 twice (pointers wrap) -> data intact;
   - with count=5, assert in_flush together with in_write -> count=0, flags cleared, write discarded.
